// File: rtl/sim_pkg.sv
// Shared definitions for the Game-of-Life simulation sequencer.
//   sim_state_e      : sequencer FSM states
//   DEF_BASE_PERIOD  : default cycles per generation at the slowest speed
//   DEF_DEBOUNCE_CYC : default stable cycles before a debounced input changes
//   DEF_TIMEOUT_CYC  : default cycle budget for one engine generation
package sim_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WAIT   = 3'd1,
    UPDATE = 3'd2,
    SWAP   = 3'd3,
    CLEAR  = 3'd4
  } sim_state_e;

  localparam int DEF_BASE_PERIOD  = 100_000_000;
  localparam int DEF_DEBOUNCE_CYC = 1_000_000;
  localparam int DEF_TIMEOUT_CYC  = 50_000_000;

endpackage

// File: rtl/sim_debounce.sv
// Switch/button conditioner: 2-flop synchroniser, stable-time debouncer and
// edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   din_i      : raw asynchronous switch level
//   rise_o     : 1-cycle pulse when the debounced level goes 0 -> 1
//   fall_o     : 1-cycle pulse when the debounced level goes 1 -> 0
module sim_debounce #(
  parameter int DEBOUNCE_CYC = sim_pkg::DEF_DEBOUNCE_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din_i,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;
  logic             rise_q;
  logic             fall_q;

  // NOTE: clocked state is only ever written with <= so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din_i};
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      // Any sample that agrees with the current level restarts the stability window.
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
        level_q <= sync_q[1];
        cnt_q   <= '0;
        rise_q  <= sync_q[1];
        fall_q  <= ~sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/sim_sequencer.sv
// Game-of-Life simulation sequencer: debounces run/clear/step controls, paces
// generations, handshakes with the engine (start/busy) and issues grid swaps.
// Optional feature macro: SIM_STEP_EN (single-step button in IDLE).
//   clk, rst_n    : clock, asynchronous active-low reset
//   sw_run        : run switch, rising edge toggles run mode
//   sw_clear      : clear switch, either edge clears the grid and stops
//   btn_step      : single-step button (used only with SIM_STEP_EN)
//   speed_sel     : speed index, period = BASE_PERIOD >> speed_sel (min 1)
//   game_busy     : engine busy
//   simulating    : run mode active
//   clear_grid    : 1-cycle pulse, clear grid
//   start_update  : 1-cycle pulse, start one engine generation
//   grid_swap     : 1-cycle pulse, swap front/back grids
//   generation    : completed generations, wraps
//   fault         : sticky engine-timeout flag, cleared by a clear
module sim_sequencer
  import sim_pkg::*;
#(
  parameter int BASE_PERIOD  = DEF_BASE_PERIOD,
  parameter int NUM_SPEEDS   = 4,
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
  parameter int GEN_W        = 16,
  localparam int SPD_W       = (NUM_SPEEDS > 1) ? $clog2(NUM_SPEEDS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sw_run,
  input  logic             sw_clear,
  input  logic             btn_step,
  input  logic [SPD_W-1:0] speed_sel,
  input  logic             game_busy,
  output logic             simulating,
  output logic             clear_grid,
  output logic             start_update,
  output logic             grid_swap,
  output logic [GEN_W-1:0] generation,
  output logic             fault
);

  localparam int TMR_W = $clog2(BASE_PERIOD + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  // Value loaded into the wait timer; WAIT lasts exactly one period because the
  // start is issued in the cycle the timer reads zero.
  function automatic logic [TMR_W-1:0] reload_val(input logic [SPD_W-1:0] sel);
    logic [TMR_W-1:0] p;
    p = TMR_W'(BASE_PERIOD) >> sel;
    if (p == '0) p = TMR_W'(1);
    return p - TMR_W'(1);
  endfunction

  // ---------------- input conditioning ----------------
  logic run_rise, clr_rise, clr_fall, step_rise;
  logic unused_run_fall;

  sim_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_run_db (
    .clk(clk), .rst_n(rst_n), .din_i(sw_run), .rise_o(run_rise), .fall_o(unused_run_fall)
  );

  sim_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_clr_db (
    .clk(clk), .rst_n(rst_n), .din_i(sw_clear), .rise_o(clr_rise), .fall_o(clr_fall)
  );

`ifdef SIM_STEP_EN
  logic unused_step_fall;
  sim_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_step_db (
    .clk(clk), .rst_n(rst_n), .din_i(btn_step), .rise_o(step_rise), .fall_o(unused_step_fall)
  );
`else
  // The step button is deliberately ignored in this build.
  logic unused_step;
  assign unused_step = btn_step;
  assign step_rise   = 1'b0;
`endif

  logic clr_edge;
  assign clr_edge = clr_rise | clr_fall;

  // ---------------- FSM and datapath state ----------------
  sim_state_e       state_q, state_d;
  logic             sim_q, sim_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             fault_q, fault_d;
  logic             clr_pend_q, clr_pend_d;
  logic             run_pend_q, run_pend_d;
  logic             seen_busy_q, seen_busy_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             start_q, start_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sim_q       <= 1'b0;
      timer_q     <= '0;
      gen_q       <= '0;
      fault_q     <= 1'b0;
      clr_pend_q  <= 1'b0;
      run_pend_q  <= 1'b0;
      seen_busy_q <= 1'b0;
      to_cnt_q    <= '0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sim_q       <= sim_d;
      timer_q     <= timer_d;
      gen_q       <= gen_d;
      fault_q     <= fault_d;
      clr_pend_q  <= clr_pend_d;
      run_pend_q  <= run_pend_d;
      seen_busy_q <= seen_busy_d;
      to_cnt_q    <= to_cnt_d;
      start_q     <= start_d;
    end
  end

  // NOTE: every signal driven here gets a hold-value default first, so no
  // path through the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    sim_d       = sim_q;
    timer_d     = timer_q;
    gen_d       = gen_q;
    fault_d     = fault_q;
    clr_pend_d  = clr_pend_q;
    run_pend_d  = run_pend_q;
    seen_busy_d = seen_busy_q;
    to_cnt_d    = to_cnt_q;
    start_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (clr_edge) begin
          state_d = CLEAR;
        end else if (run_rise) begin
          sim_d   = 1'b1;
          timer_d = reload_val(speed_sel);
          state_d = WAIT;
        end else if (step_rise && !sim_q) begin
          start_d     = 1'b1;
          seen_busy_d = 1'b0;
          to_cnt_d    = '0;
          clr_pend_d  = 1'b0;
          run_pend_d  = 1'b0;
          state_d     = UPDATE;
        end
      end

      WAIT: begin
        if (clr_edge) begin
          state_d = CLEAR;
        end else if (run_rise) begin
          sim_d   = 1'b0;
          state_d = IDLE;
        end else if (timer_q == '0) begin
          start_d     = 1'b1;
          seen_busy_d = 1'b0;
          to_cnt_d    = '0;
          clr_pend_d  = 1'b0;
          run_pend_d  = 1'b0;
          state_d     = UPDATE;
        end else if (!game_busy) begin
          timer_d = timer_q - TMR_W'(1);
        end
      end

      UPDATE: begin
        if (game_busy) seen_busy_d = 1'b1;
        // A clear arriving together with a run edge swallows the run edge.
        if (clr_edge)      clr_pend_d = 1'b1;
        else if (run_rise) run_pend_d = 1'b1;
        to_cnt_d = to_cnt_q + TO_W'(1);
        // Done requires busy to have been seen, so a late-starting engine is
        // never mistaken for a finished one.
        if (seen_busy_q && !game_busy) begin
          state_d = (clr_pend_q || clr_edge) ? CLEAR : SWAP;
        end else if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
          fault_d = 1'b1;
          sim_d   = 1'b0;
          state_d = (clr_pend_q || clr_edge) ? CLEAR : IDLE;
        end
      end

      SWAP: begin
        gen_d = gen_q + GEN_W'(1);
        if (clr_edge) begin
          state_d = CLEAR;
        end else if (sim_q && !run_pend_q && !run_rise) begin
          timer_d = reload_val(speed_sel);
          state_d = WAIT;
        end else begin
          sim_d   = 1'b0;
          state_d = IDLE;
        end
      end

      CLEAR: begin
        sim_d      = 1'b0;
        gen_d      = '0;
        fault_d    = 1'b0;
        clr_pend_d = 1'b0;
        run_pend_d = 1'b0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Pulses are decoded from distinct states (start only in the first UPDATE
  // cycle), so at most one of them is high in any cycle.
  always_comb begin
    clear_grid   = (state_q == CLEAR);
    grid_swap    = (state_q == SWAP);
    start_update = start_q;
  end

  assign simulating = sim_q;
  assign generation = gen_q;
  assign fault      = fault_q;

endmodule

// File: tb/tb_sim_sequencer.sv
// Self-checking bench for sim_sequencer with small timing parameters.
module tb_sim_sequencer;

  localparam int BASE_PERIOD  = 16;
  localparam int NUM_SPEEDS   = 4;
  localparam int DEBOUNCE_CYC = 4;
  localparam int TIMEOUT_CYC  = 64;
  localparam int GEN_W        = 4;

  localparam int W_START = 0;
  localparam int W_SWAP  = 1;
  localparam int W_CLEAR = 2;
  localparam int W_FAULT = 3;
  localparam int W_SIM1  = 4;
  localparam int W_SIM0  = 5;

  logic             clk, rst_n;
  logic             sw_run, sw_clear, btn_step, game_busy;
  logic [1:0]       speed_sel;
  logic             simulating, clear_grid, start_update, grid_swap, fault;
  logic [GEN_W-1:0] generation;

  sim_sequencer #(
    .BASE_PERIOD(BASE_PERIOD), .NUM_SPEEDS(NUM_SPEEDS), .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .TIMEOUT_CYC(TIMEOUT_CYC), .GEN_W(GEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_run(sw_run), .sw_clear(sw_clear), .btn_step(btn_step),
    .speed_sel(speed_sel), .game_busy(game_busy), .simulating(simulating),
    .clear_grid(clear_grid), .start_update(start_update), .grid_swap(grid_swap),
    .generation(generation), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int start_cnt = 0, swap_cnt = 0, clear_cnt = 0, overlap_cnt = 0;
  int exp_gen = 0;
  int busy_len = 5;
  bit engine_stuck = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor and generation reference model (wraps at 2^GEN_W).
  always @(negedge clk) begin
    if (start_update) start_cnt <= start_cnt + 1;
    if (grid_swap) begin
      swap_cnt <= swap_cnt + 1;
      exp_gen  <= (exp_gen + 1) % (1 << GEN_W);
    end
    if (clear_grid) begin
      clear_cnt <= clear_cnt + 1;
      exp_gen   <= 0;
    end
    if (int'(start_update) + int'(grid_swap) + int'(clear_grid) > 1)
      overlap_cnt <= overlap_cnt + 1;
  end

  // Engine model: goes busy half a cycle after a start pulse, for busy_len
  // cycles, or until released when engine_stuck is set.
  initial begin
    game_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (start_update && rst_n) begin
        game_busy = 1'b1;
        if (engine_stuck) begin
          while (engine_stuck) @(negedge clk);
        end else begin
          repeat (busy_len) @(negedge clk);
        end
        game_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit sig_hit(input int which);
    case (which)
      W_START: return start_update;
      W_SWAP:  return grid_swap;
      W_CLEAR: return clear_grid;
      W_FAULT: return fault;
      W_SIM1:  return simulating;
      default: return !simulating;
    endcase
  endfunction

  // Waits (bounded) for a condition at a falling edge; t is the cycle stamp.
  task automatic wait_sig(input string name, input int which, input int budget, output int t);
    bit hit;
    hit = 1'b0;
    t   = -1;
    for (int i = 0; i < budget && !hit; i++) begin
      @(negedge clk);
      hit = sig_hit(which);
    end
    if (hit) t = cyc;
    else begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: not seen within %0d cycles", name, budget);
    end
  endtask

  task automatic run_pulse();
    sw_run = 1'b1;
    repeat (8) @(negedge clk);
    sw_run = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    logic [1:0] spd;
    int         exp_gap;   // cycles between start pulses
  } vec_t;

  vec_t vec[4];

  initial begin
    int t0, t1, s0, w0, c0;
    bit got15;

    // Start-to-start gap = UPDATE (1 cycle before busy + 5 busy) + SWAP (1)
    // + WAIT (period) = period + 7.
    vec[0] = '{spd: 2'd0, exp_gap: 16 + 7};
    vec[1] = '{spd: 2'd1, exp_gap: 8 + 7};
    vec[2] = '{spd: 2'd2, exp_gap: 4 + 7};
    vec[3] = '{spd: 2'd3, exp_gap: 2 + 7};

    rst_n = 1'b0; sw_run = 1'b0; sw_clear = 1'b0; btn_step = 1'b0; speed_sel = 2'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_sim",   simulating,   0);
    check("reset_clear", clear_grid,   0);
    check("reset_start", start_update, 0);
    check("reset_swap",  grid_swap,    0);
    check("reset_gen",   generation,   0);
    check("reset_fault", fault,        0);

    // ---- run at speed 0, generations 1..3 ----
    run_pulse();
    check("run_on", simulating, 1);
    for (int g = 1; g <= 3; g++) begin
      wait_sig("swap_gen", W_SWAP, 100, t0);
      @(negedge clk);
      check($sformatf("gen_%0d", g), generation, g);
    end

    // ---- pacing per speed (table) ----
    for (int i = 0; i < 4; i++) begin
      speed_sel = vec[i].spd;
      wait_sig("start_a", W_START, 100, t0);
      wait_sig("start_b", W_START, 100, t1);
      check($sformatf("gap_spd%0d", vec[i].spd), t1 - t0, vec[i].exp_gap);
    end

    // ---- generation wrap at speed 3 ----
    got15 = 1'b0;
    for (int i = 0; i < 40 && !got15; i++) begin
      wait_sig("swap_wrap", W_SWAP, 50, t0);
      @(negedge clk);
      got15 = (exp_gen == 15);
    end
    check("gen_15", generation, 15);
    wait_sig("swap_wrap0", W_SWAP, 50, t0);
    @(negedge clk);
    check("gen_wrap0", generation, 0);

    // ---- stop run ----
    speed_sel = 2'd0;
    run_pulse();
    wait_sig("run_off", W_SIM0, 200, t0);
    repeat (10) @(negedge clk);
    s0 = start_cnt;
    repeat (40) @(negedge clk);
    check("stopped_no_start", start_cnt - s0, 0);

    // ---- glitch rejected, long press accepted ----
    sw_run = 1'b1;
    repeat (2) @(negedge clk);
    sw_run = 1'b0;
    repeat (20) @(negedge clk);
    check("glitch_sim", simulating, 0);
    sw_run = 1'b1;
    repeat (10) @(negedge clk);
    check("held_sim", simulating, 1);
    sw_run = 1'b0;

    // ---- clear during UPDATE ----
    busy_len = 20;
    wait_sig("start_clr", W_START, 100, t0);
    sw_clear = 1'b1;
    w0 = swap_cnt;
    c0 = clear_cnt;
    wait_sig("clear_pulse", W_CLEAR, 100, t1);
    check("clear_after_busy", game_busy, 0);
    @(negedge clk);
    check("clear_no_swap", swap_cnt - w0, 0);
    check("clear_one_pulse", clear_cnt - c0, 1);
    check("clear_sim", simulating, 0);
    check("clear_gen", generation, 0);
    busy_len = 5;
    sw_clear = 1'b0;
    wait_sig("clear_release", W_CLEAR, 50, t1);
    s0 = start_cnt;
    repeat (40) @(negedge clk);
    check("clear_no_start", start_cnt - s0, 0);

    // ---- engine timeout ----
    engine_stuck = 1'b1;
    w0 = swap_cnt;
    run_pulse();
    wait_sig("start_to", W_START, 100, t0);
    wait_sig("fault_set", W_FAULT, 200, t1);
    check("timeout_cycles", t1 - t0, TIMEOUT_CYC);
    check("timeout_sim", simulating, 0);
    check("timeout_no_swap", swap_cnt - w0, 0);
    engine_stuck = 1'b0;
    s0 = start_cnt;
    repeat (40) @(negedge clk);
    check("timeout_no_restart", start_cnt - s0, 0);
    check("fault_sticky", fault, 1);
    sw_clear = 1'b1;
    wait_sig("fault_clear", W_CLEAR, 50, t1);
    @(negedge clk);
    check("fault_cleared", fault, 0);
    sw_clear = 1'b0;
    wait_sig("fault_clear2", W_CLEAR, 50, t1);
    repeat (5) @(negedge clk);

    // ---- single step with simulation stopped ----
    s0 = start_cnt;
    w0 = swap_cnt;
    btn_step = 1'b1;
    repeat (8) @(negedge clk);
    btn_step = 1'b0;
    repeat (60) @(negedge clk);
`ifdef SIM_STEP_EN
    check("step_starts", start_cnt - s0, 1);
    check("step_swaps",  swap_cnt - w0,  1);
    check("step_gen",    generation,     1);
`else
    check("step_starts", start_cnt - s0, 0);
    check("step_swaps",  swap_cnt - w0,  0);
    check("step_gen",    generation,     0);
`endif
    check("step_sim", simulating, 0);

    // ---- reset in the middle of an update ----
    run_pulse();
    wait_sig("start_rst", W_START, 100, t0);
    repeat (2) @(negedge clk);
    w0 = swap_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_sim",   simulating, 0);
    check("midrst_gen",   generation, 0);
    check("midrst_start", start_update, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("midrst_no_swap", swap_cnt - w0, 0);

    check("pulse_overlap", overlap_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
